// File: rtl/mips_mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state codes, the
// opcodes it decodes and the datapath mux/ALU select encodings.
package mips_mc_pkg;

  localparam logic [3:0] StFetch   = 4'd0;
  localparam logic [3:0] StDecode  = 4'd1;
  localparam logic [3:0] StMemAdr  = 4'd2;
  localparam logic [3:0] StMemRd   = 4'd3;
  localparam logic [3:0] StMemWb   = 4'd4;
  localparam logic [3:0] StMemWr   = 4'd5;
  localparam logic [3:0] StExecute = 4'd6;
  localparam logic [3:0] StAluWb   = 4'd7;
  localparam logic [3:0] StBranch  = 4'd8;
  localparam logic [3:0] StAddiEx  = 4'd9;
  localparam logic [3:0] StAddiWb  = 4'd10;
  localparam logic [3:0] StJump    = 4'd11;
  localparam logic [3:0] StFault   = 4'd15;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // alu_src_b select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // alu_op select
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // pc_src select
  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // States that wait on the memory handshake and are subject to the timeout.
  function automatic logic is_mem_wait(logic [3:0] st);
    return (st == StFetch) || (st == StMemRd) || (st == StMemWr);
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational output decode for the multi-cycle MIPS controller.
// Inputs : state_i (current state), mem_ready_i, zero_i.
// Outputs: all datapath controls, pc_en_o and fault_o. FETCH is Mealy on
//          mem_ready_i (ir_write/pc_en); BRANCH is Mealy on zero_i.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       pc_en_o,
  output logic       fault_o
);

  logic pc_write;
  logic pc_write_cond;

  always_comb begin
    iord_o        = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SrcBReg;
    alu_op_o      = AluAdd;
    pc_src_o      = PcAlu;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    fault_o       = 1'b0;
    case (state_i)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        ir_write_o  = mem_ready_i;
        pc_write    = mem_ready_i;
      end
      StDecode:  alu_src_b_o = SrcBImmSh;
      StMemAdr, StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
      end
      StMemRd: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
      end
      StMemWb: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      StMemWr: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      StExecute: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluFunct;
      end
      StAluWb: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o   = 1'b1;
        alu_op_o      = AluSub;
        pc_src_o      = PcAluOut;
        pc_write_cond = 1'b1;
      end
      StAddiWb:  reg_write_o = 1'b1;
      StJump: begin
        pc_src_o = PcJump;
        pc_write = 1'b1;
      end
      StFault:   fault_o = 1'b1;
      default: ;
    endcase
    pc_en_o = pc_write | (pc_write_cond & zero_i);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: state register, memory wait counter with
// optional timeout, and reset gating of the write/enable outputs.
// Inputs : clk_i, rst_ni (async active-low), opcode_i, zero_i, mem_ready_i.
// Outputs: datapath controls (via mips_mc_outdec), state_o, fault_o.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       pc_en_o,
  output logic [3:0] state_o,
  output logic       fault_o
);

  // Wide enough that the counter can always reach MEM_TIMEOUT.
  localparam int unsigned CntW = (MEM_TIMEOUT > 15) ? $clog2(MEM_TIMEOUT + 1) : 4;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  logic            dec_mem_read, dec_mem_write, dec_ir_write, dec_reg_write, dec_pc_en;

  assign timeout = (MEM_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= MEM_TIMEOUT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StFetch: begin
        if (mem_ready_i)  state_d = StDecode;
        else if (timeout) state_d = StFault;
      end
      StDecode: begin
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFault;
        endcase
      end
      StMemAdr: begin
        if (opcode_i == OpLw)      state_d = StMemRd;
        else if (opcode_i == OpSw) state_d = StMemWr;
        else                       state_d = StFault;
      end
      StMemRd: begin
        if (mem_ready_i)  state_d = StMemWb;
        else if (timeout) state_d = StFault;
      end
      StMemWr: begin
        if (mem_ready_i)  state_d = StFetch;
        else if (timeout) state_d = StFault;
      end
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      StFault:   state_d = StFault;
      default:   state_d = StFault;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (is_mem_wait(state_q) && !mem_ready_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mips_mc_outdec u_outdec (
    .state_i      (state_q),
    .mem_ready_i  (mem_ready_i),
    .zero_i       (zero_i),
    .iord_o       (iord_o),
    .mem_read_o   (dec_mem_read),
    .mem_write_o  (dec_mem_write),
    .ir_write_o   (dec_ir_write),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_write_o  (dec_reg_write),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_src_o     (pc_src_o),
    .pc_en_o      (dec_pc_en),
    .fault_o      (fault_o)
  );

  // The reset state is FETCH, which would otherwise drive mem_read; mask every
  // side-effecting enable while reset is held low.
  assign mem_read_o  = dec_mem_read  & rst_ni;
  assign mem_write_o = dec_mem_write & rst_ni;
  assign ir_write_o  = dec_ir_write  & rst_ni;
  assign reg_write_o = dec_reg_write & rst_ni;
  assign pc_en_o     = dec_pc_en     & rst_ni;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, fault;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic t4_iord, t4_mem_read, t4_mem_write, t4_ir_write, t4_reg_dst, t4_mem_to_reg, t4_reg_write;
  logic t4_alu_src_a, t4_pc_en, t4_fault;
  logic [1:0] t4_alu_src_b, t4_alu_op, t4_pc_src;
  logic [3:0] t4_state;

  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_src_o(pc_src),
    .pc_en_o(pc_en), .state_o(state), .fault_o(fault)
  );

  mips_mc_ctrl #(.MEM_TIMEOUT(4)) dut_t4 (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .iord_o(t4_iord), .mem_read_o(t4_mem_read), .mem_write_o(t4_mem_write),
    .ir_write_o(t4_ir_write), .reg_dst_o(t4_reg_dst), .mem_to_reg_o(t4_mem_to_reg),
    .reg_write_o(t4_reg_write), .alu_src_a_o(t4_alu_src_a), .alu_src_b_o(t4_alu_src_b),
    .alu_op_o(t4_alu_op), .pc_src_o(t4_pc_src), .pc_en_o(t4_pc_en), .state_o(t4_state),
    .fault_o(t4_fault)
  );

  // Packed view: iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  // alu_src_b[1:0],alu_op[1:0],pc_src[1:0],pc_en,fault
  logic [15:0] obs, obs4;
  assign obs  = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_src, pc_en, fault};
  assign obs4 = {t4_iord, t4_mem_read, t4_mem_write, t4_ir_write, t4_reg_dst, t4_mem_to_reg,
                 t4_reg_write, t4_alu_src_a, t4_alu_src_b, t4_alu_op, t4_pc_src, t4_pc_en, t4_fault};
  localparam logic [15:0] EnMask = 16'h7202;  // mem_read, mem_write, ir_write, reg_write, pc_en

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-state Moore outputs, written straight from the state descriptions.
  logic [15:0] out_tab [16];

  function automatic logic [15:0] exp_outs(input int st, input logic rdy, input logic z);
    logic [15:0] v;
    v = out_tab[st];
    if (st == 0 && rdy) v = v | 16'h1002;
    if (st == 8 && z)   v = v | 16'h0002;
    return v;
  endfunction

  // Reference model: each instruction is a list of states after DECODE, as nibbles
  // consumed LSB first; an exhausted list yields 0 = FETCH.
  int          m_state, m_wait;
  logic [31:0] m_rest;

  function automatic logic [31:0] path_of(input logic [5:0] op);
    case (op)
      6'b100011: return 32'h432;
      6'b101011: return 32'h52;
      6'b000000: return 32'h76;
      6'b000100: return 32'h8;
      6'b001000: return 32'hA9;
      6'b000010: return 32'hB;
      default:   return 32'hF;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_rest = 0;
  endtask

  task automatic model_step(input int to);
    int  nxt;
    logic waiting;
    waiting = (m_state == 0) || (m_state == 3) || (m_state == 5);
    nxt = m_state;
    if (m_state == 15) nxt = 15;
    else if (waiting && !mem_ready) begin
      if (to != 0 && m_wait + 1 >= to) nxt = 15;
    end else if (m_state == 0) nxt = 1;
    else begin
      if (m_state == 1) m_rest = path_of(opcode);
      nxt = int'(m_rest[3:0]);
      m_rest = m_rest >> 4;
    end
    if (nxt != m_state) m_wait = 0;
    else if (waiting && !mem_ready && m_wait < 15) m_wait++;
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse(input string nm);
    rst_n = 1'b0;
    #1;
    check({nm, "_state"}, state, 0);
    check({nm, "_en"}, obs & EnMask, 0);
    check({nm, "_fault"}, fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int st, input string nm);
    int k = 0;
    while (state !== st[3:0] && k < 20) begin
      tick(); k++;
    end
    check(nm, state, st);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        z;
    int          lat;
    logic [31:0] trace;
    int          n_regw;
    int          n_pcen;
  } vec_t;

  vec_t vecs [7];

  logic [5:0] legal_ops [6];

  initial begin
    int stall;
    out_tab = '{default: 16'h0000};
    out_tab[0]  = 16'h4040; out_tab[1]  = 16'h00C0; out_tab[2]  = 16'h0180;
    out_tab[3]  = 16'hC000; out_tab[4]  = 16'h0600; out_tab[5]  = 16'hA000;
    out_tab[6]  = 16'h0120; out_tab[7]  = 16'h0A00; out_tab[8]  = 16'h0114;
    out_tab[9]  = 16'h0180; out_tab[10] = 16'h0200; out_tab[11] = 16'h000A;
    out_tab[15] = 16'h0001;

    vecs[0] = '{6'b100011, 1'b0, 5, 32'h43210, 1, 1};
    vecs[1] = '{6'b101011, 1'b0, 4, 32'h5210,  0, 1};
    vecs[2] = '{6'b000000, 1'b0, 4, 32'h7610,  1, 1};
    vecs[3] = '{6'b001000, 1'b0, 4, 32'hA910,  1, 1};
    vecs[4] = '{6'b000100, 1'b1, 3, 32'h810,   0, 2};
    vecs[5] = '{6'b000100, 1'b0, 3, 32'h810,   0, 1};
    vecs[6] = '{6'b000010, 1'b0, 3, 32'hB10,   0, 2};
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    // Reset state, then release between edges.
    #2;
    check("rst_state", state, 0);
    check("rst_en", obs & EnMask, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("fetch_outs", obs, 16'h4040);

    // Zero-wait latency/trace table.
    mem_ready = 1'b1;
    foreach (vecs[v]) begin
      logic [31:0] tr;
      int k, rw, pe;
      opcode = vecs[v].op; zero = vecs[v].z;
      tr = 0; k = 0; rw = 0; pe = 0;
      do begin
        #1;
        tr = tr | (32'(state) << (4 * k));
        rw += int'(reg_write); pe += int'(pc_en);
        tick(); k++;
      end while (state !== 4'd0 && k < 12);
      check($sformatf("vec%0d_lat", v), k, vecs[v].lat);
      check($sformatf("vec%0d_trace", v), tr, vecs[v].trace);
      check($sformatf("vec%0d_regw", v), rw, vecs[v].n_regw);
      check($sformatf("vec%0d_pcen", v), pe, vecs[v].n_pcen);
    end

    // sw with memory stalled three cycles in MEMWR.
    opcode = 6'b101011;
    run_to(5, "sw_reach_memwr");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sw_hold_state", state, 5);
      check("sw_hold_wr", mem_write, 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("sw_done_wr", mem_write, 1);
    tick();
    check("sw_back_fetch", state, 0);

    // Timeout of 4 with mem_ready stuck low in FETCH.
    reset_pulse("to_rst");
    mem_ready = 1'b0;
    begin
      int k = 0;
      #1;
      while (t4_state === 4'd0 && k < 10) begin tick(); k++; end
      check("to_cycles", k, 4);
      check("to_state", t4_state, 15);
      repeat (5) tick();
      check("to_sticky", obs4, 16'h0001);
      check("to_default_fetch", state, 0);
    end
    reset_pulse("to_clr");
    #1;
    check("to_clr_fault", t4_fault, 0);

    // Illegal opcode.
    opcode = 6'b111111; mem_ready = 1'b1;
    tick(); tick();
    check("ill_state", state, 15);
    check("ill_fault", fault, 1);
    reset_pulse("ill_rst");

    // Reset during ALUWB.
    opcode = 6'b000000;
    run_to(7, "r_reach_aluwb");
    check("aluwb_regw", reg_write, 1);
    reset_pulse("aluwb_rst");

    // Randomized run against the model.
    model_reset();
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0)
        opcode = ($urandom % 10 == 0) ? 6'($urandom) : legal_ops[$urandom % 6];
      zero = 1'($urandom);
      if (stall > 0) begin
        mem_ready = 1'b0; stall--;
      end else begin
        mem_ready = ($urandom % 3) != 0;
        if ($urandom % 50 == 0) stall = $urandom_range(4, 20);
      end
      #1;
      check("rand_state", state, m_state);
      check("rand_outs", obs, exp_outs(m_state, mem_ready, zero));
      if (m_state == 15 || $urandom % 100 == 0) begin
        reset_pulse("rand_rst");
        model_reset();
        stall = 0;
      end
      model_step(15);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max wait cycles per memory state; 0 disables the timeout.
REQ-002 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: opcode  input  6  instruction[31:26] from the instruction register, valid from DECODE onward.
REQ-005 Port: zero  input  1  ALU zero flag.
REQ-006 Port: mem_ready  input  1  memory handshake; the access completes in the cycle it is 1.
REQ-007 Ports: iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-008 Ports: alu_src_b  output  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2); alu_op  output  2  (00 add, 01 sub, 10 funct); pc_src  output  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 Ports: pc_en  output  1  PC load = pc_write OR (pc_write_cond AND zero); state  output  4  current state; fault  output  1  sticky error flag.

Function
REQ-010 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, FAULT=15; codes 12-14 go to FAULT on the next edge.
REQ-011 Any output not listed for the current state SHALL be 0.
REQ-012 FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=00, pc_src=00.
REQ-013 FETCH, continued: ir_write and pc_en equal mem_ready (Mealy); go to DECODE on mem_ready=1, else hold.
REQ-014 DECODE: alu_src_b=11, alu_op=00.
REQ-015 DECODE next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP; any other opcode -> FAULT.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw -> MEMRD, sw -> MEMWR.
REQ-017 MEMRD: iord=1, mem_read=1; on mem_ready -> MEMWB, else hold.
REQ-018 MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0; then FETCH.
REQ-019 MEMWR: iord=1, mem_write=1; on mem_ready -> FETCH, else hold.
REQ-020 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB.
REQ-021 ALUWB: reg_dst=1, reg_write=1; then FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; then FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
REQ-024 ADDIWB: reg_dst=0, reg_write=1; then FETCH.
REQ-025 JUMP: pc_src=10, pc_en=1; then FETCH.
REQ-026 Wait counter (4 bits minimum, saturating) increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0, and clears on any state change.
REQ-027 With MEM_TIMEOUT>0, reaching MEM_TIMEOUT while mem_ready=0 goes to FAULT; mem_ready=1 in that same cycle completes normally instead.
REQ-028 FAULT: all enables 0, fault=1; remains in FAULT until reset.
REQ-029 Latencies with zero-wait memory: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3.

Reset
REQ-030 Reset assertion SHALL immediately set state=FETCH, counter=0, fault=0.
REQ-031 While reset is low, all read/write/enable outputs SHALL be forced to 0.
REQ-032 After release, the first FETCH access starts on the first rising edge with reset high.
REQ-033 Reset asserted mid-instruction aborts that instruction with no further write enables.

Structure
REQ-034 A shared package holds the state codes, opcode constants and the alu_src_b/alu_op/pc_src encodings.
REQ-035 Sub-module mips_mc_outdec: purely combinational decode of (state, mem_ready, zero) to outputs.
REQ-036 The registered state and counter are kept in mips_mc_ctrl.

Verification
REQ-037 Scenario, lw with mem_ready=1: opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB.
REQ-038 Scenario, beq: opcode=000100 with zero=1 -> pc_en=1 and pc_src=01 in BRANCH; with zero=0 -> pc_en=0.
REQ-039 Scenario, sw with mem_ready low 3 cycles in MEMWR -> 3 hold cycles, mem_write held at 1, then FETCH.
REQ-040 Scenario, MEM_TIMEOUT=4 and mem_ready stuck 0 in FETCH -> FAULT after 4 cycles; fault=1 until reset.
REQ-041 Scenario, illegal opcode 111111 in DECODE -> FAULT; pulsing reset low returns to FETCH with fault=0.
REQ-042 Scenario, reset asserted in ALUWB -> reg_write drops to 0 immediately and state=0.
